tile_flush_sched: RTL and testbench
===================================

# tile_flush_sched

Frame-level scheduler for the tile pipeline, running entirely in the `gpu_clk` domain. It walks a framebuffer as a grid of 32×32-pixel tiles and hands each tile to the rasterizer in one of two ping-pong tile-RAM banks. When a bank is complete, it launches the tile writer on that bank with the tile's framebuffer address and stride. It signals frame completion only after the writer's FIFO has fully drained to the Avalon side.

## Interface

Parameters:
- `TILE_ROW_BYTES`, 64: byte advance between horizontally adjacent tiles (32 px × 16 bpp).
- `TILE_ROWS_LOG2`, 5: log2 of pixel rows per tile; vertical tile advance is `stride << TILE_ROWS_LOG2`.

Ports:
- `gpu_clk`  in  1  clock.
- `gpu_rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle request to start a frame.
- `fb_base`  in  32  framebuffer byte address of tile (0,0); sampled with `frame_start`.
- `fb_stride`  in  16  framebuffer row pitch in bytes; sampled with `frame_start`.
- `tiles_x`, `tiles_y`  in  8 each  grid size in tiles; sampled with `frame_start`.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `render_go`  out  1  one-cycle pulse; rasterizer starts a tile.
- `render_tile_x`, `render_tile_y`  out  8 each  coordinates of the current tile.
- `render_bank`  out  1  bank the rasterizer writes.
- `render_done`  in  1  one-cycle pulse; rasterizer finished the current tile.
- `wr_start`  out  1  one-cycle start to the tile writer.
- `wr_addr`  out  32  tile framebuffer address; valid while `wr_start` is high.
- `wr_stride`  out  16  registered copy of `fb_stride`.
- `wr_bank`  out  1  bank the tile writer reads.
- `wr_reading`  in  1  tile writer is reading its bank.
- `wr_flushed`  in  1  tile writer is idle and its FIFO is empty.

## Operation

- **Reset:** every output is 0. `bank_full[1:0]` is 0, both bank pointers are 0, and all FSMs are in their idle state.
- **Frame start:** `frame_start` is accepted only when `busy` is 0 and ignored otherwise. On acceptance, the block latches the configuration and zeroes the tile coordinates, `row_addr`, `tile_addr`, and both bank pointers.
- **Empty grid:** if `tiles_x == 0` or `tiles_y == 0`, the block issues no tiles and pulses `frame_done` on the cycle after acceptance.
- **Render FSM:**
  - R_IDLE → R_ISSUE on acceptance.
  - R_ISSUE: if `bank_full[render_bank]` is set, go to R_WAIT_BANK. Otherwise pulse `render_go`, store `tile_addr` into `bank_addr[render_bank]`, and go to R_RENDER.
  - R_WAIT_BANK → R_ISSUE when the bank clears.
  - R_RENDER: on `render_done`, set `bank_full[render_bank]`, toggle `render_bank`, and advance the tile. Go to R_ISSUE, or to R_FLUSH after the last tile.
  - R_FLUSH → R_IDLE with a `frame_done` pulse when `bank_full == 0`, the writer FSM is in W_IDLE, and `wr_flushed` is 1.
- **Tile advance (raster order):**
  - Within a row: `tile_x++` and `tile_addr += TILE_ROW_BYTES`.
  - At `tile_x == tiles_x-1`: `tile_x = 0`, `tile_y++`, `row_addr += fb_stride << TILE_ROWS_LOG2`, and `tile_addr = new row_addr`.
  - All address arithmetic is 32-bit, modulo 2^32; `row_addr` is 32-bit.
- **Writer FSM:**
  - W_IDLE: if `bank_full[wr_bank]` is set, go to W_LAUNCH.
  - W_LAUNCH: `wr_start` = 1 and `wr_addr` = `bank_addr[wr_bank]`, for one cycle; go to W_ACK.
  - W_ACK: wait for `wr_reading == 1`.
  - W_DRAIN: wait for `wr_reading == 0`, then clear `bank_full[wr_bank]`, toggle `wr_bank`, and go to W_IDLE.
- **Simultaneous events:** a set and a clear on different banks in the same cycle both take effect. `render_done` outside R_RENDER is ignored.

## Timing

- `frame_start` accepted in cycle t → `busy` and `render_go` high in cycle t+1.
- `render_done` in cycle t → `bank_full` visible in t+1 → `wr_start` high in t+2.
- The rasterizer may start the other bank at t+1, overlapping the flush.
- A bank is reusable one cycle after the writer's `wr_reading` falls.
- `frame_done` is high for exactly one cycle. `busy` falls in the same cycle as the `frame_done` pulse.
- **Reset mid-frame:** `gpu_rst_n` low immediately clears all outputs and state. The partially flushed tile is abandoned, and the tile writer is reset by its own reset.

## Configuration

- **`TILE_FLUSH_SCHED_PERF_EN` defined:** adds two 32-bit output ports.
  - `perf_frame_cycles`: counts the cycles during which `busy` is 1.
  - `perf_stall_cycles`: counts the cycles spent in R_WAIT_BANK.
  - Both clear on frame acceptance, saturate at 0xFFFFFFFF, hold after `frame_done`, and reset to 0.
- **Not defined:** the ports and counters are absent; behaviour is otherwise identical.

## Test plan

- `fb_base`=0x1000_0000, `stride`=1280, 2×2 tiles, instant writer model → `wr_addr` sequence 0x1000_0000, 0x1000_0040, 0x1000_A000, 0x1000_A040; one `frame_done`.
- `tiles_x`=0 → no `render_go` and no `wr_start`; `frame_done` at acceptance+1.
- Writer holding `wr_reading` for 200 cycles, rasterizer taking 10 cycles per tile, 4×1 tiles → third `render_go` delayed until bank 0 drains; `perf_stall_cycles` > 0 (PERF build).
- `wr_flushed` held low for 50 cycles after the last drain → `frame_done` waits until `wr_flushed` rises.
- `frame_start` pulsed mid-frame → ignored; configuration and address sequence are unchanged.
- `gpu_rst_n` asserted while in W_DRAIN → all outputs 0 next edge; a new frame then runs correctly from bank 0.

Source files
------------

// File: rtl/tile_flush_sched.sv
// tile_flush_sched: walks a frame as 32x32 tiles, alternating two tile-RAM banks between rasterizer and tile writer.
// Optional define TILE_FLUSH_SCHED_PERF_EN adds perf_frame_cycles / perf_stall_cycles counters.
module tile_flush_sched #(
    parameter int unsigned TILE_ROW_BYTES = 64,
    parameter int unsigned TILE_ROWS_LOG2 = 5
) (
    input  logic        gpu_clk,
    input  logic        gpu_rst_n,
    input  logic        frame_start,
    input  logic [31:0] fb_base,
    input  logic [15:0] fb_stride,
    input  logic [7:0]  tiles_x,
    input  logic [7:0]  tiles_y,
    output logic        busy,
    output logic        frame_done,
    output logic        render_go,
    output logic [7:0]  render_tile_x,
    output logic [7:0]  render_tile_y,
    output logic        render_bank,
    input  logic        render_done,
    output logic        wr_start,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_stride,
    output logic        wr_bank,
    input  logic        wr_reading,
    input  logic        wr_flushed,
`ifdef TILE_FLUSH_SCHED_PERF_EN
    output logic [31:0] perf_frame_cycles,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic [2:0]  dbg_render_state,
    output logic [1:0]  dbg_wr_state
);

    typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_WAIT_BANK, R_RENDER, R_FLUSH} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_LAUNCH, W_ACK, W_DRAIN} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;
    logic [1:0]  bank_full;
    logic [31:0] bank_addr [2];
    logic [31:0] cfg_base;
    logic [7:0]  cfg_tiles_x;
    logic [7:0]  cfg_tiles_y;
    logic [31:0] row_addr;
    logic [31:0] tile_addr;

    logic        accept;
    logic        empty_grid;
    logic        last_col;
    logic        last_tile;
    logic        render_fin;
    logic        drain_fin;
    logic [1:0]  set_mask;
    logic [1:0]  clr_mask;
    logic [31:0] row_step;

    assign accept     = frame_start && !busy;
    assign empty_grid = (tiles_x == 8'd0) || (tiles_y == 8'd0);
    assign last_col   = (render_tile_x == cfg_tiles_x - 8'd1);
    assign last_tile  = last_col && (render_tile_y == cfg_tiles_y - 8'd1);
    assign render_fin = (r_state == R_RENDER) && render_done;
    assign drain_fin  = (w_state == W_DRAIN) && !wr_reading;
    assign set_mask   = render_fin ? (2'b01 << render_bank) : 2'b00;
    assign clr_mask   = drain_fin ? (2'b01 << wr_bank) : 2'b00;
    assign row_step   = {16'd0, wr_stride} << TILE_ROWS_LOG2;

    // Decoded from state so a tile launches in the very cycle its bank is seen free.
    assign render_go  = (r_state == R_ISSUE) && !bank_full[render_bank];

    assign dbg_render_state = r_state;
    assign dbg_wr_state     = w_state;

    always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
        if (!gpu_rst_n) begin
            r_state       <= R_IDLE;
            w_state       <= W_IDLE;
            bank_full     <= 2'b00;
            bank_addr[0]  <= '0;
            bank_addr[1]  <= '0;
            cfg_base      <= '0;
            cfg_tiles_x   <= '0;
            cfg_tiles_y   <= '0;
            row_addr      <= '0;
            tile_addr     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            render_tile_x <= '0;
            render_tile_y <= '0;
            render_bank   <= 1'b0;
            wr_start      <= 1'b0;
            wr_addr       <= '0;
            wr_stride     <= '0;
            wr_bank       <= 1'b0;
`ifdef TILE_FLUSH_SCHED_PERF_EN
            perf_frame_cycles <= '0;
            perf_stall_cycles <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            // Set and clear always target different banks, so both apply together.
            bank_full  <= (bank_full | set_mask) & ~clr_mask;

            case (w_state)
                W_IDLE: begin
                    if (bank_full[wr_bank]) begin
                        wr_start <= 1'b1;
                        wr_addr  <= bank_addr[wr_bank];
                        w_state  <= W_LAUNCH;
                    end
                end
                W_LAUNCH: begin
                    wr_start <= 1'b0;
                    w_state  <= W_ACK;
                end
                W_ACK: begin
                    if (wr_reading) w_state <= W_DRAIN;
                end
                W_DRAIN: begin
                    if (!wr_reading) begin
                        wr_bank <= ~wr_bank;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase

            case (r_state)
                R_IDLE: begin
                    if (accept) begin
                        cfg_base      <= fb_base;
                        cfg_tiles_x   <= tiles_x;
                        cfg_tiles_y   <= tiles_y;
                        wr_stride     <= fb_stride;
                        render_tile_x <= '0;
                        render_tile_y <= '0;
                        row_addr      <= '0;
                        tile_addr     <= '0;
                        render_bank   <= 1'b0;
                        wr_bank       <= 1'b0;
                        if (empty_grid) begin
                            frame_done <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= R_ISSUE;
                        end
                    end
                end
                R_ISSUE: begin
                    if (bank_full[render_bank]) begin
                        r_state <= R_WAIT_BANK;
                    end else begin
                        bank_addr[render_bank] <= cfg_base + tile_addr;
                        r_state                <= R_RENDER;
                    end
                end
                R_WAIT_BANK: begin
                    if (!bank_full[render_bank]) r_state <= R_ISSUE;
                end
                R_RENDER: begin
                    if (render_done) begin
                        render_bank <= ~render_bank;
                        if (last_col) begin
                            render_tile_x <= '0;
                            render_tile_y <= render_tile_y + 8'd1;
                            row_addr      <= row_addr + row_step;
                            tile_addr     <= row_addr + row_step;
                        end else begin
                            render_tile_x <= render_tile_x + 8'd1;
                            tile_addr     <= tile_addr + 32'(TILE_ROW_BYTES);
                        end
                        r_state <= last_tile ? R_FLUSH : R_ISSUE;
                    end
                end
                R_FLUSH: begin
                    // Frame ends only once both banks are empty and the writer FIFO has drained.
                    if (bank_full == 2'b00 && w_state == W_IDLE && wr_flushed) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase

`ifdef TILE_FLUSH_SCHED_PERF_EN
            if (r_state == R_IDLE && accept) begin
                perf_frame_cycles <= '0;
                perf_stall_cycles <= '0;
            end else begin
                if (busy && perf_frame_cycles != 32'hFFFF_FFFF)
                    perf_frame_cycles <= perf_frame_cycles + 32'd1;
                if (r_state == R_WAIT_BANK && perf_stall_cycles != 32'hFFFF_FFFF)
                    perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tile_flush_sched.sv
// Bench for tile_flush_sched: rasterizer/writer responder models, event monitor and a raster-order scoreboard.
`timescale 1ns/1ps
module tb_tile_flush_sched;

    localparam int TILE_BYTES = 64;
    localparam int TILE_ROWS  = 32;

    logic        gpu_clk     = 1'b0;
    logic        gpu_rst_n   = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] fb_base     = '0;
    logic [15:0] fb_stride   = '0;
    logic [7:0]  tiles_x     = '0;
    logic [7:0]  tiles_y     = '0;
    logic        busy;
    logic        frame_done;
    logic        render_go;
    logic [7:0]  render_tile_x;
    logic [7:0]  render_tile_y;
    logic        render_bank;
    logic        render_done = 1'b0;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [15:0] wr_stride;
    logic        wr_bank;
    logic        wr_reading  = 1'b0;
    logic        wr_flushed  = 1'b1;
    logic [2:0]  dbg_render_state;
    logic [1:0]  dbg_wr_state;
`ifdef TILE_FLUSH_SCHED_PERF_EN
    logic [31:0] perf_frame_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // responder knobs
    int rast_dly   = 3;
    int wr_ack_dly = 0;
    int wr_hold    = 1;
    int flush_dly  = 0;

    tile_flush_sched dut (
        .gpu_clk          (gpu_clk),
        .gpu_rst_n        (gpu_rst_n),
        .frame_start      (frame_start),
        .fb_base          (fb_base),
        .fb_stride        (fb_stride),
        .tiles_x          (tiles_x),
        .tiles_y          (tiles_y),
        .busy             (busy),
        .frame_done       (frame_done),
        .render_go        (render_go),
        .render_tile_x    (render_tile_x),
        .render_tile_y    (render_tile_y),
        .render_bank      (render_bank),
        .render_done      (render_done),
        .wr_start         (wr_start),
        .wr_addr          (wr_addr),
        .wr_stride        (wr_stride),
        .wr_bank          (wr_bank),
        .wr_reading       (wr_reading),
        .wr_flushed       (wr_flushed),
`ifdef TILE_FLUSH_SCHED_PERF_EN
        .perf_frame_cycles(perf_frame_cycles),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .dbg_render_state (dbg_render_state),
        .dbg_wr_state     (dbg_wr_state)
    );

    // clock / cycle counter
    always #5 gpu_clk = ~gpu_clk;
    always @(posedge gpu_clk) cyc <= cyc + 1;

    // monitor state
    logic [15:0] go_xy_q[$];
    logic        go_bank_q[$];
    int          go_cyc_q[$];
    logic [31:0] wa_q[$];
    logic        wb_q[$];
    int          ws_cyc_q[$];
    int          rd_cyc_q[$];
    int          wm_fall_q[$];
    int          fd_count, fd_cyc, first_busy, busy_cnt;
    logic        fd_busy, fd_prev_busy, prev_busy;
    int          wm_last_fall, wm_last_rise;

    always @(negedge gpu_clk) begin
        if (gpu_rst_n) begin
            if (render_go) begin
                go_xy_q.push_back({render_tile_x, render_tile_y});
                go_bank_q.push_back(render_bank);
                go_cyc_q.push_back(cyc);
            end
            if (wr_start) begin
                wa_q.push_back(wr_addr);
                wb_q.push_back(wr_bank);
                ws_cyc_q.push_back(cyc);
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc       = cyc;
                fd_busy      = busy;
                fd_prev_busy = prev_busy;
            end
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    // rasterizer model: finishes a tile rast_dly cycles after render_go
    int rm_phase = 0;
    int rm_cnt   = 0;
    always @(negedge gpu_clk) begin
        if (!gpu_rst_n) begin
            rm_phase    = 0;
            render_done = 1'b0;
        end else if (rm_phase == 0) begin
            render_done = 1'b0;
            if (render_go) begin
                rm_cnt   = rast_dly;
                rm_phase = 1;
            end
        end else if (rm_cnt > 1) begin
            rm_cnt--;
        end else begin
            render_done = 1'b1;
            rd_cyc_q.push_back(cyc);
            rm_phase = 0;
        end
    end

    // tile writer model: ack, read for wr_hold cycles, then FIFO drains flush_dly cycles later
    int wm_phase  = 0;
    int wm_cnt    = 0;
    int flush_cnt = 0;
    always @(negedge gpu_clk) begin
        if (!gpu_rst_n) begin
            wm_phase   = 0;
            flush_cnt  = 0;
            wr_reading = 1'b0;
            wr_flushed = 1'b1;
        end else begin
            case (wm_phase)
                0: begin
                    if (wr_start) begin
                        wr_flushed = 1'b0;
                        flush_cnt  = 0;
                        wm_cnt     = wr_ack_dly;
                        wm_phase   = 1;
                    end else if (flush_cnt > 0) begin
                        flush_cnt--;
                        if (flush_cnt == 0) begin
                            wr_flushed   = 1'b1;
                            wm_last_rise = cyc;
                        end
                    end
                end
                1: begin
                    if (wm_cnt > 0) begin
                        wm_cnt--;
                    end else begin
                        wr_reading = 1'b1;
                        wm_cnt     = wr_hold;
                        wm_phase   = 2;
                    end
                end
                default: begin
                    if (wm_cnt > 1) begin
                        wm_cnt--;
                    end else begin
                        wr_reading   = 1'b0;
                        wm_last_fall = cyc;
                        wm_fall_q.push_back(cyc);
                        if (flush_dly == 0) begin
                            wr_flushed   = 1'b1;
                            wm_last_rise = cyc;
                        end else begin
                            flush_cnt = flush_dly;
                        end
                        wm_phase = 0;
                    end
                end
            endcase
        end
    end

    // driver tasks
    task automatic clear_mon();
        go_xy_q.delete(); go_bank_q.delete(); go_cyc_q.delete();
        wa_q.delete(); wb_q.delete(); ws_cyc_q.delete();
        rd_cyc_q.delete(); wm_fall_q.delete();
        fd_count = 0; fd_cyc = -1; first_busy = -1; busy_cnt = 0;
        fd_busy = 1'b0; fd_prev_busy = 1'b0;
        wm_last_fall = -1; wm_last_rise = -1;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input logic [7:0] tx, input logic [7:0] ty, output int acc_cyc);
        @(posedge gpu_clk); #1;
        fb_base     = base;
        fb_stride   = stride;
        tiles_x     = tx;
        tiles_y     = ty;
        frame_start = 1'b1;
        acc_cyc     = cyc;
        @(posedge gpu_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input int budget);
        int n;
        n = 0;
        while (fd_count == 0 && n < budget) begin
            @(posedge gpu_clk); #2;
            n++;
        end
        tests_run++;
        if (fd_count == 0) begin
            tests_failed++;
            $display("FAIL %s frame_done timeout: got no pulse in %0d cycles, expected one", name, budget);
        end
        repeat (4) @(posedge gpu_clk);
        #1;
    endtask

    // scoreboard: expected tiles in raster order, address = base + y*stride*32 + x*64 (mod 2^32)
    task automatic scoreboard_frame(input string name, input logic [31:0] base, input logic [15:0] stride,
                                    input int tx, input int ty, input int acc_cyc);
        logic [31:0] exp_q[$];
        logic [15:0] exp_xy_q[$];
        int          exp_fd;
        for (int y = 0; y < ty; y++) begin
            for (int x = 0; x < tx; x++) begin
                exp_q.push_back(base + 32'(y) * (32'(stride) * 32'(TILE_ROWS)) + 32'(x) * 32'(TILE_BYTES));
                exp_xy_q.push_back({8'(x), 8'(y)});
            end
        end
        tests_run++;
        if (wa_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s wr_start count: got %0d expected %0d", name, wa_q.size(), exp_q.size());
        end
        tests_run++;
        if (go_xy_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s render_go count: got %0d expected %0d", name, go_xy_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < wa_q.size()) begin
                tests_run++;
                if (wa_q[k] !== exp_q[k] || wb_q[k] !== 1'(k)) begin
                    tests_failed++;
                    $display("FAIL %s wr tile %0d: got addr %h bank %0d expected addr %h bank %0d",
                             name, k, wa_q[k], wb_q[k], exp_q[k], k % 2);
                end
            end
            if (k < go_xy_q.size()) begin
                tests_run++;
                if (go_xy_q[k] !== exp_xy_q[k] || go_bank_q[k] !== 1'(k)) begin
                    tests_failed++;
                    $display("FAIL %s render tile %0d: got xy %h bank %0d expected xy %h bank %0d",
                             name, k, go_xy_q[k], go_bank_q[k], exp_xy_q[k], k % 2);
                end
            end
        end
        tests_run++;
        if (fd_count != 1 || fd_busy !== 1'b0 || fd_prev_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s frame_done: got count %0d busy %0d prev_busy %0d expected 1 0 1",
                     name, fd_count, fd_busy, fd_prev_busy);
        end
        tests_run++;
        if (wr_stride !== stride) begin
            tests_failed++;
            $display("FAIL %s wr_stride: got %0d expected %0d", name, wr_stride, stride);
        end
        if (go_cyc_q.size() > 0 && ws_cyc_q.size() > 0 && rd_cyc_q.size() > 0) begin
            tests_run++;
            if (go_cyc_q[0] != acc_cyc + 1 || first_busy != acc_cyc + 1 || ws_cyc_q[0] != rd_cyc_q[0] + 2) begin
                tests_failed++;
                $display("FAIL %s first-tile timing: got go %0d busy %0d wr_start %0d expected %0d %0d %0d",
                         name, go_cyc_q[0], first_busy, ws_cyc_q[0], acc_cyc + 1, acc_cyc + 1, rd_cyc_q[0] + 2);
            end
        end
        exp_fd = (wm_last_fall + 2 > wm_last_rise + 1) ? wm_last_fall + 2 : wm_last_rise + 1;
        tests_run++;
        if (fd_cyc != exp_fd) begin
            tests_failed++;
            $display("FAIL %s frame_done cycle: got %0d expected %0d", name, fd_cyc, exp_fd);
        end
    endtask

    // scenario tasks
    task automatic test_reset();
        repeat (3) @(posedge gpu_clk);
        #1;
        tests_run++;
        if ({busy, frame_done, render_go, render_bank, wr_start, wr_bank} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset flags: got %b expected 000000",
                     {busy, frame_done, render_go, render_bank, wr_start, wr_bank});
        end
        tests_run++;
        if ({wr_addr, wr_stride, render_tile_x, render_tile_y} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset buses: got %h expected 0", {wr_addr, wr_stride, render_tile_x, render_tile_y});
        end
        tests_run++;
        if ({dbg_render_state, dbg_wr_state} !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset fsm idle: got %b expected 00000", {dbg_render_state, dbg_wr_state});
        end
        @(posedge gpu_clk); #1;
        gpu_rst_n = 1'b1;
        repeat (2) @(posedge gpu_clk);
        #1;
    endtask

    task automatic test_basic_2x2();
        int acc;
        rast_dly = 3; wr_ack_dly = 0; wr_hold = 1; flush_dly = 0;
        clear_mon();
        start_frame(32'h1000_0000, 16'd1280, 8'd2, 8'd2, acc);
        wait_frame_done("basic_2x2", 2000);
        scoreboard_frame("basic_2x2", 32'h1000_0000, 16'd1280, 2, 2, acc);
        tests_run++;
        if (wa_q.size() != 4 || wa_q[3] !== 32'h1000_A040) begin
            tests_failed++;
            $display("FAIL basic_2x2 last addr: got %0d entries, last %h expected 4 entries, last 1000a040",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[wa_q.size() - 1] : 32'h0);
        end
    endtask

    task automatic test_empty_grid();
        int acc;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            start_frame(32'h2000_0000, 16'd640, (pass == 0) ? 8'd0 : 8'd3, (pass == 0) ? 8'd4 : 8'd0, acc);
            wait_frame_done("empty_grid", 50);
            tests_run++;
            if (go_xy_q.size() != 0 || wa_q.size() != 0 || fd_count != 1 || fd_cyc != acc + 1) begin
                tests_failed++;
                $display("FAIL empty_grid pass %0d: got go %0d wr %0d done %0d at %0d expected 0 0 1 at %0d",
                         pass, go_xy_q.size(), wa_q.size(), fd_count, fd_cyc, acc + 1);
            end
        end
    endtask

    task automatic test_bank_stall();
        int acc;
        rast_dly = 10; wr_ack_dly = 0; wr_hold = 200; flush_dly = 0;
        clear_mon();
        start_frame(32'h0004_0000, 16'd512, 8'd4, 8'd1, acc);
        wait_frame_done("bank_stall", 3000);
        scoreboard_frame("bank_stall", 32'h0004_0000, 16'd512, 4, 1, acc);
        tests_run++;
        if (go_cyc_q.size() < 3 || wm_fall_q.size() < 1 ||
            go_cyc_q[2] <= wm_fall_q[0] || go_cyc_q[2] > wm_fall_q[0] + 3) begin
            tests_failed++;
            $display("FAIL bank_stall third go: got cycle %0d expected just after bank0 drain at %0d",
                     (go_cyc_q.size() > 2) ? go_cyc_q[2] : -1, (wm_fall_q.size() > 0) ? wm_fall_q[0] : -1);
        end
`ifdef TILE_FLUSH_SCHED_PERF_EN
        tests_run++;
        if (perf_stall_cycles == 32'd0 || perf_frame_cycles != 32'(busy_cnt)) begin
            tests_failed++;
            $display("FAIL bank_stall perf: got stall %0d frame %0d expected stall >0 frame %0d",
                     perf_stall_cycles, perf_frame_cycles, busy_cnt);
        end
`endif
    endtask

    task automatic test_flush_wait();
        int acc;
        rast_dly = 2; wr_ack_dly = 1; wr_hold = 3; flush_dly = 50;
        clear_mon();
        start_frame(32'h0100_0000, 16'd256, 8'd2, 8'd1, acc);
        wait_frame_done("flush_wait", 2000);
        scoreboard_frame("flush_wait", 32'h0100_0000, 16'd256, 2, 1, acc);
        tests_run++;
        if (fd_cyc != wm_last_rise + 1 || fd_cyc < wm_last_fall + 50) begin
            tests_failed++;
            $display("FAIL flush_wait done cycle: got %0d expected %0d (flushed rise + 1)", fd_cyc, wm_last_rise + 1);
        end
    endtask

    task automatic test_mid_frame_start();
        int acc;
        rast_dly = 4; wr_ack_dly = 0; wr_hold = 5; flush_dly = 0;
        clear_mon();
        start_frame(32'h3000_0100, 16'd2048, 8'd3, 8'd2, acc);
        repeat (6) @(posedge gpu_clk);
        #1;
        fb_base = 32'h7777_0000; fb_stride = 16'd96; tiles_x = 8'd1; tiles_y = 8'd1;
        frame_start = 1'b1;
        @(posedge gpu_clk); #1;
        frame_start = 1'b0;
        wait_frame_done("mid_frame_start", 2000);
        scoreboard_frame("mid_frame_start", 32'h3000_0100, 16'd2048, 3, 2, acc);
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        int n;
        rast_dly = 2; wr_ack_dly = 0; wr_hold = 200; flush_dly = 0;
        clear_mon();
        start_frame(32'h0800_0000, 16'd1024, 8'd2, 8'd2, acc);
        n = 0;
        while (!wr_reading && n < 100) begin
            @(posedge gpu_clk); #1;
            n++;
        end
        repeat (3) @(posedge gpu_clk);
        #1;
        tests_run++;
        if (!wr_reading) begin
            tests_failed++;
            $display("FAIL reset_mid_drain setup: got no writer read within 100 cycles, expected one");
        end
        gpu_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, frame_done, render_go, render_bank, wr_start, wr_bank, dbg_render_state, dbg_wr_state} !== 11'd0 ||
            {wr_addr, wr_stride, render_tile_x, render_tile_y} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_drain outputs: got flags %b buses %h expected all 0",
                     {busy, frame_done, render_go, render_bank, wr_start, wr_bank, dbg_render_state, dbg_wr_state},
                     {wr_addr, wr_stride, render_tile_x, render_tile_y});
        end
        repeat (3) @(posedge gpu_clk);
        #1;
        gpu_rst_n = 1'b1;
        wr_hold = 2;
        repeat (2) @(posedge gpu_clk);
        clear_mon();
        start_frame(32'h0900_0040, 16'd320, 8'd3, 8'd1, acc);
        wait_frame_done("after_reset", 2000);
        scoreboard_frame("after_reset", 32'h0900_0040, 16'd320, 3, 1, acc);
    endtask

    task automatic test_address_wrap();
        int acc;
        rast_dly = 1; wr_ack_dly = 2; wr_hold = 2; flush_dly = 1;
        clear_mon();
        start_frame(32'hFFFF_F000, 16'hFFC0, 8'd3, 8'd3, acc);
        wait_frame_done("address_wrap", 3000);
        scoreboard_frame("address_wrap", 32'hFFFF_F000, 16'hFFC0, 3, 3, acc);
    endtask

    task automatic test_random_frames();
        int          acc;
        logic [31:0] base;
        logic [15:0] stride;
        int          tx, ty;
        for (int f = 0; f < 8; f++) begin
            base       = $urandom;
            stride     = 16'($urandom);
            tx         = $urandom_range(6, 1);
            ty         = $urandom_range(4, 1);
            rast_dly   = $urandom_range(8, 1);
            wr_ack_dly = $urandom_range(3, 0);
            wr_hold    = $urandom_range(12, 1);
            flush_dly  = $urandom_range(6, 0);
            clear_mon();
            start_frame(base, stride, 8'(tx), 8'(ty), acc);
            wait_frame_done("random", 5000);
            scoreboard_frame("random", base, stride, tx, ty, acc);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_2x2();
        test_empty_grid();
        test_bank_stall();
        test_flush_wait();
        test_mid_frame_start();
        test_reset_mid_drain();
        test_address_wrap();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
